// File: rtl/term_accumulator.sv
// Evaluates sum(c_k * x^k) over NUM_TERMS coefficients streamed from an external
// term counter / coefficient ROM, in signed Q(DATA_W-FRAC_W).FRAC_W fixed point.
module term_accumulator #(
  parameter int unsigned DATA_W     = 16,
  parameter int unsigned FRAC_W     = 12,
  parameter int unsigned CNTR_DEPTH = 4,
  parameter int unsigned NUM_TERMS  = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [DATA_W-1:0]     x_in,
  input  logic                  coeff_rd_en,
  input  logic [CNTR_DEPTH-1:0] term_cnt,
  input  logic [DATA_W-1:0]     coeff_data,
  output logic                  start_cntr,
  output logic                  done,
  output logic [DATA_W-1:0]     result,
  output logic                  result_valid,
  input  logic                  result_ready,
  output logic                  busy,
  output logic                  ovf
);

  localparam int unsigned ACC_W  = DATA_W + CNTR_DEPTH;
  localparam int unsigned PROD_W = 2 * DATA_W;
  localparam logic [CNTR_DEPTH-1:0]  LAST_IDX = CNTR_DEPTH'(NUM_TERMS - 1);
  localparam logic signed [DATA_W-1:0] ONE_V = DATA_W'(1 << FRAC_W);
  localparam logic signed [DATA_W-1:0] MAX_V = {1'b0, {(DATA_W-1){1'b1}}};
  localparam logic signed [DATA_W-1:0] MIN_V = {1'b1, {(DATA_W-1){1'b0}}};

  typedef enum logic [2:0] {StIdle, StLaunch, StRun, StDrain, StHold} state_e;

  state_e                    r_state;
  logic signed [DATA_W-1:0]  r_x;
  logic signed [DATA_W-1:0]  r_power;
  logic signed [ACC_W-1:0]   r_acc;
  logic [DATA_W-1:0]         r_result;
  logic                      r_term_v;
  logic                      r_start_cntr;
  logic                      r_busy;
  logic                      r_result_valid;
  logic                      r_ovf;

  logic signed [PROD_W-1:0]  w_coeff_ext, w_power_ext, w_x_ext;
  logic signed [PROD_W-1:0]  w_prod_sh, w_pow_sh;
  logic signed [ACC_W-1:0]   w_acc_next;
  logic signed [DATA_W-1:0]  w_pow_sat, w_acc_sat;
  logic                      w_pow_clip, w_acc_clip;

  always_comb begin
    w_coeff_ext = {{DATA_W{coeff_data[DATA_W-1]}}, coeff_data};
    w_power_ext = {{DATA_W{r_power[DATA_W-1]}}, r_power};
    w_x_ext     = {{DATA_W{r_x[DATA_W-1]}}, r_x};
    w_prod_sh   = (w_coeff_ext * w_power_ext) >>> FRAC_W;
    w_pow_sh    = (w_power_ext * w_x_ext) >>> FRAC_W;
    w_acc_next  = r_term_v ? r_acc + $signed(w_prod_sh[ACC_W-1:0]) : r_acc;
    // Fits in DATA_W only when all bits above the new sign bit match it.
    w_pow_clip  = ~((&w_pow_sh[PROD_W-1:DATA_W-1]) | ~(|w_pow_sh[PROD_W-1:DATA_W-1]));
    w_pow_sat   = w_pow_clip ? (w_pow_sh[PROD_W-1] ? MIN_V : MAX_V) : w_pow_sh[DATA_W-1:0];
    w_acc_clip  = ~((&w_acc_next[ACC_W-1:DATA_W-1]) | ~(|w_acc_next[ACC_W-1:DATA_W-1]));
    w_acc_sat   = w_acc_clip ? (w_acc_next[ACC_W-1] ? MIN_V : MAX_V) : w_acc_next[DATA_W-1:0];
  end

  assign done         = (r_state == StRun) & coeff_rd_en & (term_cnt == LAST_IDX);
  assign start_cntr   = r_start_cntr;
  assign result       = r_result;
  assign result_valid = r_result_valid;
  assign busy         = r_busy;
  assign ovf          = r_ovf;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state        <= StIdle;
      r_x            <= '0;
      r_power        <= '0;
      r_acc          <= '0;
      r_result       <= '0;
      r_term_v       <= 1'b0;
      r_start_cntr   <= 1'b0;
      r_busy         <= 1'b0;
      r_result_valid <= 1'b0;
      r_ovf          <= 1'b0;
    end else begin
      r_start_cntr <= 1'b0;
      // ROM data lags the read by one cycle; reads outside RUN are never consumed.
      r_term_v     <= (r_state == StRun) & coeff_rd_en;
      if (r_term_v) begin
        r_acc   <= w_acc_next;
        r_power <= w_pow_sat;
        if (w_pow_clip) r_ovf <= 1'b1;
      end
      unique case (r_state)
        StIdle: begin
          if (start) begin
            r_x          <= $signed(x_in);
            r_power      <= ONE_V;
            r_acc        <= '0;
            r_ovf        <= 1'b0;
            r_start_cntr <= 1'b1;
            r_busy       <= 1'b1;
            r_state      <= StLaunch;
          end
        end
        StLaunch: r_state <= StRun;
        StRun: begin
          if (done) r_state <= StDrain;
        end
        StDrain: begin
          r_result       <= w_acc_sat;
          if (w_acc_clip) r_ovf <= 1'b1;
          r_result_valid <= 1'b1;
          r_state        <= StHold;
        end
        StHold: begin
          if (result_ready) begin
            r_result_valid <= 1'b0;
            r_busy         <= 1'b0;
            r_state        <= StIdle;
          end
        end
        default: r_state <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_term_accumulator.sv
// Randomised bench for term_accumulator: a term-counter/ROM environment plus a
// transaction-level model of the polynomial sum and of the handshake timeline.
module tb_term_accumulator;

  localparam int DW = 16;
  localparam int FW = 12;
  localparam int CD = 4;
  localparam int NT = 8;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start;
  logic [DW-1:0] x_in;
  logic          coeff_rd_en;
  logic [CD-1:0] term_cnt;
  logic [DW-1:0] coeff_data;
  logic          start_cntr;
  logic          done;
  logic [DW-1:0] result;
  logic          result_valid;
  logic          result_ready;
  logic          busy;
  logic          ovf;

  int checks = 0;
  int errors = 0;
  int rom[NT];

  term_accumulator #(
    .DATA_W(DW), .FRAC_W(FW), .CNTR_DEPTH(CD), .NUM_TERMS(NT)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .x_in(x_in),
    .coeff_rd_en(coeff_rd_en), .term_cnt(term_cnt), .coeff_data(coeff_data),
    .start_cntr(start_cntr), .done(done), .result(result),
    .result_valid(result_valid), .result_ready(result_ready),
    .busy(busy), .ovf(ovf)
  );

  always #5 clk = ~clk;

  task automatic chk_b(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_w(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: plain integer arithmetic on the series, 20-bit wrapping accumulator.
  function automatic void model_eval(input int x, output int res, output bit ov);
    longint acc, p, prod, np;
    logic [63:0] u;
    acc = 0; p = 64'sd1 <<< FW; ov = 0;
    for (int k = 0; k < NT; k++) begin
      prod = (longint'(rom[k]) * p) >>> FW;
      acc  = acc + prod;
      u    = acc;
      acc  = longint'($signed(u[DW+CD-1:0]));
      np   = (p * longint'(x)) >>> FW;
      if (np > 32767) begin np = 32767; ov = 1; end
      else if (np < -32768) begin np = -32768; ov = 1; end
      p = np;
    end
    if (acc > 32767) begin res = 32767; ov = 1; end
    else if (acc < -32768) begin res = -32768; ov = 1; end
    else res = int'(acc);
  endfunction

  // Term counter + coefficient ROM environment.
  initial begin : env
    bit s_sc, s_dn, s_re, active;
    logic [CD-1:0] s_cnt;
    int cnt;
    coeff_rd_en = 1'b0; term_cnt = '0; coeff_data = '0; active = 0; cnt = 0;
    forever begin
      @(negedge clk);
      s_sc = start_cntr; s_dn = done; s_re = coeff_rd_en; s_cnt = term_cnt;
      @(posedge clk); #1;
      if (!rst_n) begin
        active = 0; cnt = 0; coeff_rd_en = 1'b0; term_cnt = '0; coeff_data = '0;
      end else begin
        coeff_data = s_re ? DW'(rom[int'(s_cnt) % NT]) : DW'($urandom);
        if (s_dn) begin active = 0; cnt = 0; end
        else if (s_re && active) cnt++;
        if (s_sc) begin active = 1; cnt = 0; end
        if (active) begin
          coeff_rd_en = ($urandom_range(0, 3) != 0);
          term_cnt    = CD'(cnt);
        end else begin
          coeff_rd_en = ($urandom_range(0, 5) == 0);
          term_cnt    = CD'($urandom);
        end
      end
    end
  end

  // Compare process: expected handshake timeline and result per cycle.
  initial begin : compare
    int cyc, launch_cyc, done_cyc, r;
    bit m_busy, m_hold, m_done_seen, exp_done, o;
    logic [DW-1:0] m_exp_res, m_last_res;
    bit m_exp_ovf, m_last_ovf;
    cyc = 0; launch_cyc = -10; done_cyc = -10;
    m_busy = 0; m_hold = 0; m_done_seen = 0;
    m_exp_res = '0; m_last_res = '0; m_exp_ovf = 0; m_last_ovf = 0;
    forever begin
      @(negedge clk);
      cyc++;
      if (!rst_n) begin
        chk_b("rst_start_cntr", start_cntr, 1'b0);
        chk_b("rst_done", done, 1'b0);
        chk_b("rst_valid", result_valid, 1'b0);
        chk_b("rst_busy", busy, 1'b0);
        chk_b("rst_ovf", ovf, 1'b0);
        chk_w("rst_result", result, '0);
        m_busy = 0; m_hold = 0; m_done_seen = 0; launch_cyc = -10; done_cyc = -10;
        m_last_res = '0; m_last_ovf = 0;
      end else begin
        exp_done = m_busy && !m_done_seen && (cyc > launch_cyc) && coeff_rd_en
                   && (term_cnt == CD'(NT - 1));
        chk_b("start_cntr", start_cntr, cyc == launch_cyc);
        chk_b("busy", busy, m_busy);
        chk_b("result_valid", result_valid, m_hold);
        chk_b("done", done, exp_done);
        if (m_hold) begin
          chk_w("hold_result", result, m_exp_res);
          chk_b("hold_ovf", ovf, m_exp_ovf);
        end else if (!m_busy) begin
          chk_w("idle_result", result, m_last_res);
          chk_b("idle_ovf", ovf, m_last_ovf);
        end else if (cyc == launch_cyc) begin
          chk_b("launch_ovf_clear", ovf, 1'b0);
        end
        if (!m_busy && start) begin
          m_busy = 1; m_done_seen = 0; launch_cyc = cyc + 1;
          model_eval(int'($signed(x_in)), r, o);
          m_exp_res = DW'(r); m_exp_ovf = o;
        end else if (m_hold && result_ready) begin
          m_hold = 0; m_busy = 0; m_last_res = m_exp_res; m_last_ovf = m_exp_ovf;
        end else if (exp_done) begin
          m_done_seen = 1; done_cyc = cyc;
        end else if (m_done_seen && cyc == done_cyc + 1) begin
          m_hold = 1;
        end
      end
    end
  end

  task automatic do_run(input logic [DW-1:0] x, input int hold, input bit pulse,
                        input bit start_acc, input bit lit, input logic [DW-1:0] exp_r,
                        input bit exp_o);
    int n;
    start = 1'b1; x_in = x;
    @(posedge clk); #1;
    start = 1'b0; x_in = DW'($urandom);
    n = 0;
    while (!result_valid && n < 200) begin
      result_ready = 1'($urandom % 2);
      @(posedge clk); #1;
      n++;
    end
    result_ready = 1'b0;
    if (!result_valid) begin
      checks++; errors++;
      $display("FAIL run_timeout: got no result_valid required within 200 cycles");
      return;
    end
    if (lit) begin
      chk_w("lit_result", result, exp_r);
      chk_b("lit_ovf", ovf, exp_o);
    end
    for (int i = 0; i < hold; i++) begin
      start = pulse ? 1'($urandom % 2) : 1'b0;
      @(posedge clk); #1;
    end
    result_ready = 1'b1; start = start_acc;
    @(posedge clk); #1;
    result_ready = 1'b0; start = 1'b0;
    if (lit) begin
      chk_b("idle_after_accept_busy", busy, 1'b0);
      chk_b("idle_after_accept_valid", result_valid, 1'b0);
    end
  endtask

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: simulation did not reach its end");
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    int r, n;
    bit o;
    rst_n = 1'b0; start = 1'b0; x_in = '0; result_ready = 1'b0;
    for (int k = 0; k < NT; k++) rom[k] = 4096;
    model_eval(32'sh0800, r, o);
    chk_w("model_half", DW'(r), 16'h1FE0); chk_b("model_half_ovf", o, 1'b0);
    model_eval(32'sh1000, r, o);
    chk_w("model_one", DW'(r), 16'h7FFF); chk_b("model_one_ovf", o, 1'b1);
    model_eval(-4096, r, o);
    chk_w("model_neg1", DW'(r), 16'h0000); chk_b("model_neg1_ovf", o, 1'b0);

    repeat (3) @(posedge clk);
    #2 rst_n = 1'b1;
    @(posedge clk); #1;
    do_run(16'h0800, 2, 0, 0, 1, 16'h1FE0, 0);
    do_run(16'h1000, 1, 0, 0, 1, 16'h7FFF, 1);
    do_run(16'hF000, 3, 0, 0, 1, 16'h0000, 0);
    // Long hold with start noise, then an immediate second run that must clear ovf.
    do_run(16'h1000, 10, 1, 1, 1, 16'h7FFF, 1);
    do_run(16'h0800, 0, 0, 0, 1, 16'h1FE0, 0);

    // Reset in the middle of RUN.
    start = 1'b1; x_in = 16'h1000;
    @(posedge clk); #1;
    start = 1'b0;
    n = 0;
    while (!(busy && coeff_rd_en && term_cnt == CD'(3)) && n < 100) begin
      @(posedge clk); #2;
      n++;
    end
    if (n >= 100) begin
      checks++; errors++;
      $display("FAIL reset_wait: got no term_cnt=3 read required within 100 cycles");
    end
    rst_n = 1'b0;
    #1;
    chk_b("async_rst_busy", busy, 1'b0);
    chk_b("async_rst_start_cntr", start_cntr, 1'b0);
    chk_b("async_rst_done", done, 1'b0);
    chk_b("async_rst_valid", result_valid, 1'b0);
    chk_b("async_rst_ovf", ovf, 1'b0);
    chk_w("async_rst_result", result, '0);
    @(posedge clk); #2 rst_n = 1'b1;
    @(posedge clk); #1;
    do_run(16'h0800, 1, 0, 0, 1, 16'h1FE0, 0);

    for (int t = 0; t < 24; t++) begin
      for (int k = 0; k < NT; k++)
        rom[k] = (t % 2 == 0) ? int'($urandom_range(0, 8192)) - 4096
                              : int'($signed(16'($urandom)));
      if (t % 3 == 0) x_in = DW'($urandom);
      else x_in = DW'(int'($urandom_range(0, 12288)) - 6144);
      do_run(x_in, int'($urandom_range(0, 4)), 1'($urandom % 2), 1'($urandom % 2), 0,
             '0, 0);
    end
    repeat (3) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/term_accumulator.md
TERM_ACCUMULATOR -- requirements
Module: term_accumulator

Interface
REQ-001 SHALL have parameter DATA_W, default 16, meaning signed fixed-point data width of x, coefficients and result.
REQ-002 SHALL have parameter FRAC_W, default 12, meaning fractional bits (Q4.12; 1.0 = 0x1000).
REQ-003 SHALL have parameter CNTR_DEPTH, default 4, meaning width of term index.
REQ-004 SHALL have parameter NUM_TERMS, default 8, meaning number of series terms summed (2..2^CNTR_DEPTH).
REQ-005 SHALL have port clk, input, 1, meaning clock; all state updates on rising edge.
REQ-006 SHALL have port rst_n, input, 1, meaning reset: asynchronous, active-low.
REQ-007 SHALL have port start, input, 1, meaning request a new evaluation; sampled only in IDLE.
REQ-008 SHALL have port x_in, input, DATA_W, meaning signed argument x; captured on an accepted start.
REQ-009 SHALL have port coeff_rd_en, input, 1, meaning term counter read enable; the coefficient ROM returns data one cycle later.
REQ-010 SHALL have port term_cnt, input, CNTR_DEPTH, meaning current term index from the term counter.
REQ-011 SHALL have port coeff_data, input, DATA_W, meaning signed coefficient c_k; valid in the cycle after coeff_rd_en.
REQ-012 SHALL have port start_cntr, output, 1, meaning one-cycle pulse that starts the term counter.
REQ-013 SHALL have port done, output, 1, meaning one-cycle pulse that stops and clears the term counter.
REQ-014 SHALL have port result, output, DATA_W, meaning saturated sum of c_k*x^k for k = 0..NUM_TERMS-1.
REQ-015 SHALL have port result_valid, output, 1, meaning result is held stable until accepted.
REQ-016 SHALL have port result_ready, input, 1, meaning consumer accepts result when high with result_valid.
REQ-017 SHALL have port busy, output, 1, meaning high in every state except IDLE.
REQ-018 SHALL have port ovf, output, 1, meaning sticky flag: saturation occurred during the current evaluation.

Function
REQ-019 SHALL implement FSM states IDLE, LAUNCH, RUN, DRAIN and HOLD.
REQ-020 SHALL, in IDLE on start=1, latch x_in, set power=1.0, acc=0, ovf=0 and go to LAUNCH.
REQ-021 SHALL assert start_cntr for exactly the single LAUNCH cycle, then go to RUN.
REQ-022 SHALL drive done = (state==RUN) & coeff_rd_en & (term_cnt==NUM_TERMS-1), combinationally in that cycle, and then go to DRAIN.
REQ-023 SHALL register coeff_rd_en into term_v; when term_v=1, product = coeff_data*power, computed at full 2*DATA_W width and then arithmetically right-shifted by FRAC_W (truncation toward negative infinity).
REQ-024 SHALL hold acc at DATA_W+CNTR_DEPTH bits, with acc <= acc + product on each term_v, the product sign-extended before the add.
REQ-025 SHALL, on each term_v, update power <= (power*x)>>>FRAC_W saturated to DATA_W, and set ovf if that saturation clips.
REQ-026 SHALL, in DRAIN (final coefficient term_v cycle), accumulate the last term, then register result = acc saturated to DATA_W.
REQ-027 SHALL saturate result to 0x7FFF/0x8000 (DATA_W=16) and set ovf when clipping occurs; then go to HOLD.
REQ-028 SHALL hold result_valid=1 with result stable in HOLD, and return to IDLE on result_ready=1; result_valid then drops the next cycle.
REQ-029 SHALL ignore start in every state other than IDLE, including the HOLD cycle in which result_ready completes.
REQ-030 SHALL ignore result_ready when result_valid=0.
REQ-031 SHALL ignore coeff_rd_en and coeff_data outside RUN/DRAIN; accumulation uses term_v only.
REQ-032 SHALL have a latency, with D the done cycle: last term accumulated at the end of D+1, result_valid high from D+2.

Reset
REQ-033 SHALL, while rst_n=0 (asynchronously, including mid-evaluation), force state=IDLE and result=0.
REQ-034 SHALL, under the same reset, force start_cntr=0, done=0 (done is combinational from state), result_valid=0, busy=0 and ovf=0.
REQ-035 SHALL, under the same reset, clear acc, power, term_v and latched x to 0.

Verification
REQ-036 SHALL verify: x=0x0800, all c_k=0x1000, NUM_TERMS=8 -> result=0x1FE0, ovf=0, exactly one start_cntr and one done pulse.
REQ-037 SHALL verify: x=0x1000, all c_k=0x1000 -> internal sum 0x8000 -> result=0x7FFF, ovf=1.
REQ-038 SHALL verify: x=0xF000 (-1.0), all c_k=0x1000 -> alternating terms, result=0x0000, ovf=0.
REQ-039 SHALL verify: result_ready held low 10 cycles in HOLD with start pulsed -> result_valid and result stable, no start_cntr; ready=1 -> IDLE next cycle.
REQ-040 SHALL verify: rst_n asserted during RUN at term_cnt=3 -> all outputs 0 immediately; a following start with x=0x0800 yields 0x1FE0.
REQ-041 SHALL verify: back-to-back runs, with start asserted the cycle after IDLE is re-entered -> second run accepted, and ovf from the first run cleared.
